// File: rtl/fsk_modulator.sv
`default_nettype none
// ============================================================================
// Module   : fsk_modulator
// Brief    : Continuous-phase binary FSK modulator with a 4-deep bit FIFO,
//            rendering each bit as SAMPLES_PER_BIT triangle-wave samples.
// Revision : 1.0 - initial release
// ============================================================================
module fsk_modulator #(
   parameter int SAMPLES_PER_BIT = 16,
   parameter int PHASE_W         = 10,
   parameter int STEP0           = 16,
   parameter int STEP1           = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ser_in,
   input  logic       ser_valid,
   output logic [7:0] mod_out,
   output logic       mod_valid,
   output logic       busy,
   output logic       overflow
);

   localparam int                 c_cnt_w = $clog2(SAMPLES_PER_BIT);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(SAMPLES_PER_BIT - 1);
   localparam logic [PHASE_W-1:0] c_step0 = PHASE_W'(STEP0);
   localparam logic [PHASE_W-1:0] c_step1 = PHASE_W'(STEP1);
   localparam logic [7:0]         c_mid   = 8'd128;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t               r_state, w_state_n;
   logic [PHASE_W-1:0]   r_phase, w_phase_n, w_phase_inc, w_step;
   logic [c_cnt_w-1:0]   r_sym_cnt, w_sym_n;
   logic                 r_cur_bit, w_cur_n;
   logic [7:0]           r_mod_out, w_out_n, w_tri;
   logic                 r_mod_valid, w_valid_n;
   logic                 r_overflow;
   logic [8:0]           w_p;

   logic [3:0]           r_mem;
   logic [1:0]           r_wr_ptr, r_rd_ptr;
   logic [2:0]           r_count;
   logic                 w_pop, w_push, w_full, w_drop, w_nonempty;

   assign w_nonempty = (r_count != 3'd0);
   assign w_full     = (r_count == 3'd4);
   // A full FIFO still accepts a bit when a slot is freed on the same edge.
   assign w_push     = ser_valid & (~w_full | w_pop);
   assign w_drop     = ser_valid & w_full & ~w_pop;

   assign w_step      = r_cur_bit ? c_step1 : c_step0;
   assign w_phase_inc = r_phase + w_step;
   assign w_p         = w_phase_inc[PHASE_W-1 -: 9];
   assign w_tri       = w_p[8] ? (8'd255 - w_p[7:0]) : w_p[7:0];

   always_comb begin
      w_state_n = r_state;
      w_phase_n = r_phase;
      w_sym_n   = r_sym_cnt;
      w_cur_n   = r_cur_bit;
      w_out_n   = r_mod_out;
      w_valid_n = r_mod_valid;
      w_pop     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_out_n   = c_mid;
            w_valid_n = 1'b0;
            if (w_nonempty) begin
               w_pop     = 1'b1;
               w_cur_n   = r_mem[r_rd_ptr];
               w_phase_n = '0;
               w_sym_n   = '0;
               w_state_n = S_RUN;
            end
         end
         S_RUN: begin
            w_phase_n = w_phase_inc;
            w_out_n   = w_tri;
            w_valid_n = 1'b1;
            w_sym_n   = r_sym_cnt + 1'b1;
            // Symbol boundary: chain the next bit without resetting phase.
            if (r_sym_cnt == c_last) begin
               if (w_nonempty) begin
                  w_pop   = 1'b1;
                  w_cur_n = r_mem[r_rd_ptr];
                  w_sym_n = '0;
               end else begin
                  w_state_n = S_IDLE;
               end
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_phase     <= '0;
         r_sym_cnt   <= '0;
         r_cur_bit   <= 1'b0;
         r_mod_out   <= c_mid;
         r_mod_valid <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_phase     <= w_phase_n;
         r_sym_cnt   <= w_sym_n;
         r_cur_bit   <= w_cur_n;
         r_mod_out   <= w_out_n;
         r_mod_valid <= w_valid_n;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mem      <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= ser_in;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign mod_out   = r_mod_out;
   assign mod_valid = r_mod_valid;
   assign overflow  = r_overflow;
   assign busy      = (r_state == S_RUN) | w_nonempty;

endmodule
`default_nettype wire

// File: tb/tb_fsk_modulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsk_modulator
// Brief    : Directed self-checking bench for fsk_modulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsk_modulator;

   logic       clk;
   logic       reset;
   logic       ser_in;
   logic       ser_valid;
   logic [7:0] mod_out;
   logic       mod_valid;
   logic       busy;
   logic       overflow;

   int n_cmp;
   int n_err;

   fsk_modulator dut (
      .clk       (clk),
      .reset     (reset),
      .ser_in    (ser_in),
      .ser_valid (ser_valid),
      .mod_out   (mod_out),
      .mod_valid (mod_valid),
      .busy      (busy),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      ser_valid = 1'b0;
      ser_in    = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
   endtask

   function automatic logic [7:0] tri_ref(input int ph);
      int p;
      p = (ph % 1024) / 2;
      return (p < 256) ? 8'(p) : 8'(511 - p);
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ser_valid = (i % 2 == 0);
         ser_in    = (i % 3 == 0);
         tick();
         n_cmp++;
         if (mod_out !== 8'd128 || mod_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: got out=%0d v=%b busy=%b ovf=%b expected out=128 v=0 busy=0 ovf=0",
                     mod_out, mod_valid, busy, overflow);
         end
      end
      ser_valid = 1'b0;
      ser_in    = 1'b0;
      reset     = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         n_cmp++;
         if (mod_out !== 8'd128 || mod_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle cyc %0d: got out=%0d v=%b busy=%b ovf=%b expected out=128 v=0 busy=0 ovf=0",
                     i, mod_out, mod_valid, busy, overflow);
         end
      end
   endtask

   task automatic test_single_zero();
      logic [7:0] exp;
      do_reset();
      ser_in    = 1'b0;
      ser_valid = 1'b1;
      tick();
      ser_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || mod_valid !== 1'b0) begin
         n_err++;
         $display("FAIL zero_edge1: got busy=%b v=%b expected busy=1 v=0", busy, mod_valid);
      end
      tick();
      n_cmp++;
      if (mod_valid !== 1'b0 || mod_out !== 8'd128) begin
         n_err++;
         $display("FAIL zero_edge2: got v=%b out=%0d expected v=0 out=128", mod_valid, mod_out);
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         exp = 8'((i + 1) * 8);
         n_cmp++;
         if (mod_valid !== 1'b1 || mod_out !== exp) begin
            n_err++;
            $display("FAIL zero_sample %0d: got v=%b out=%0d expected v=1 out=%0d", i, mod_valid, mod_out, exp);
         end
      end
      tick();
      n_cmp++;
      if (mod_valid !== 1'b0 || mod_out !== 8'd128 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL zero_end: got v=%b out=%0d busy=%b expected v=0 out=128 busy=0", mod_valid, mod_out, busy);
      end
   endtask

   task automatic test_single_one();
      logic [7:0] exp;
      do_reset();
      ser_in    = 1'b1;
      ser_valid = 1'b1;
      tick();
      ser_valid = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         tick();
         exp = (i < 15) ? 8'((i + 1) * 16) : 8'd255;
         n_cmp++;
         if (mod_valid !== 1'b1 || mod_out !== exp) begin
            n_err++;
            $display("FAIL one_sample %0d: got v=%b out=%0d expected v=1 out=%0d", i, mod_valid, mod_out, exp);
         end
      end
      tick();
      n_cmp++;
      if (mod_valid !== 1'b0 || mod_out !== 8'd128) begin
         n_err++;
         $display("FAIL one_end: got v=%b out=%0d expected v=0 out=128", mod_valid, mod_out);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      do_reset();
      ser_in    = 1'b0;
      ser_valid = 1'b1;
      tick();
      ser_in = 1'b1;
      tick();
      ser_valid = 1'b0;
      ser_in    = 1'b0;
      for (int i = 0; i < 32; i++) begin
         tick();
         if (i < 16)      exp = 8'((i + 1) * 8);
         else if (i < 23) exp = 8'(144 + 16 * (i - 16));
         else if (i == 23) exp = 8'd255;
         else             exp = 8'(255 - 16 * (i - 23));
         n_cmp++;
         if (mod_valid !== 1'b1 || mod_out !== exp) begin
            n_err++;
            $display("FAIL b2b_sample %0d: got v=%b out=%0d expected v=1 out=%0d", i, mod_valid, mod_out, exp);
         end
      end
      tick();
      n_cmp++;
      if (mod_valid !== 1'b0 || mod_out !== 8'd128) begin
         n_err++;
         $display("FAIL b2b_end: got v=%b out=%0d expected v=0 out=128", mod_valid, mod_out);
      end
   endtask

   task automatic test_overflow();
      logic [5:0] pat;
      logic [7:0] exp;
      logic       b;
      logic       exp_v;
      int         ph;
      int         nsamp;
      pat   = 6'b101101;
      ph    = 0;
      nsamp = 0;
      do_reset();
      for (int e = 1; e <= 90; e++) begin
         ser_valid = (e <= 6);
         ser_in    = (e <= 6) ? pat[e-1] : 1'b0;
         tick();
         if (e == 5) begin
            n_cmp++;
            if (overflow !== 1'b0) begin
               n_err++;
               $display("FAIL ovf_before: got %b expected 0", overflow);
            end
         end
         if (e == 6) begin
            n_cmp++;
            if (overflow !== 1'b1) begin
               n_err++;
               $display("FAIL ovf_set: got %b expected 1", overflow);
            end
         end
         exp_v = (e >= 3 && e <= 82);
         n_cmp++;
         if (mod_valid !== exp_v) begin
            n_err++;
            $display("FAIL ovf_valid edge %0d: got %b expected %b", e, mod_valid, exp_v);
         end
         if (mod_valid === 1'b1 && nsamp < 80) begin
            b   = pat[nsamp / 16];
            ph  = (ph + (b ? 32 : 16)) % 1024;
            exp = tri_ref(ph);
            n_cmp++;
            if (mod_out !== exp) begin
               n_err++;
               $display("FAIL ovf_sample %0d: got %0d expected %0d", nsamp, mod_out, exp);
            end
         end
         if (mod_valid === 1'b1) nsamp++;
      end
      ser_valid = 1'b0;
      n_cmp++;
      if (nsamp !== 80 || overflow !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_total: got samples=%0d ovf=%b expected samples=80 ovf=1", nsamp, overflow);
      end
   endtask

   task automatic test_reset_mid_symbol();
      do_reset();
      ser_valid = 1'b1;
      ser_in    = 1'b1;
      tick();
      ser_in = 1'b0;
      tick();
      ser_in = 1'b1;
      tick();
      ser_valid = 1'b0;
      ser_in    = 1'b0;
      repeat (6) tick();
      n_cmp++;
      if (mod_valid !== 1'b1 || mod_out !== 8'd112) begin
         n_err++;
         $display("FAIL mid_sample7: got v=%b out=%0d expected v=1 out=112", mod_valid, mod_out);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (mod_out !== 8'd128 || mod_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL mid_async: got out=%0d v=%b busy=%b ovf=%b expected out=128 v=0 busy=0 ovf=0",
                  mod_out, mod_valid, busy, overflow);
      end
      repeat (2) tick();
      reset = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         n_cmp++;
         if (mod_valid !== 1'b0 || busy !== 1'b0 || mod_out !== 8'd128) begin
            n_err++;
            $display("FAIL mid_stale cyc %0d: got v=%b busy=%b out=%0d expected v=0 busy=0 out=128",
                     i, mod_valid, busy, mod_out);
         end
      end
      ser_valid = 1'b1;
      ser_in    = 1'b1;
      tick();
      ser_valid = 1'b0;
      ser_in    = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (mod_valid !== 1'b1 || mod_out !== 8'd16) begin
         n_err++;
         $display("FAIL mid_restart: got v=%b out=%0d expected v=1 out=16", mod_valid, mod_out);
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      reset     = 1'b0;
      ser_in    = 1'b0;
      ser_valid = 1'b0;
      test_reset();
      test_single_zero();
      test_single_one();
      test_back_to_back();
      test_overflow();
      test_reset_mid_symbol();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fsk_modulator.md
Name: fsk_modulator

Overview:
- Downstream stage of the serial message processor: consumes its serial bit stream (SerOut qualified by valid) and produces continuous-phase binary FSK samples for the DAC/output stage.
- A 4-entry bit FIFO absorbs upstream bursts.
- Each bit is rendered as SAMPLES_PER_BIT 8-bit triangle-wave samples from a phase accumulator. The step is STEP0 for a 0 bit and STEP1 for a 1 bit.
- The upstream stage has no backpressure, so bits that arrive while the FIFO is full are dropped and flagged.

Parameters:
- SAMPLES_PER_BIT, 16, output samples per input bit (>=2).
- PHASE_W, 10, phase accumulator width (>=9).
- STEP0, 16, phase increment per sample for bit 0.
- STEP1, 32, phase increment per sample for bit 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- ser_in  input  1  serial data bit from the upstream SerOut.
- ser_valid  input  1  ser_in is valid this cycle (upstream valid).
- mod_out  output  8  unsigned FSK sample; midscale is 128.
- mod_valid  output  1  mod_out holds a live sample this cycle.
- busy  output  1  FSM is in RUN or the FIFO is non-empty.
- overflow  output  1  sticky flag: a bit was dropped because the FIFO was full.

Behaviour:
- Reset values: mod_out=128, mod_valid=0, busy=0, overflow=0, phase=0, sym_cnt=0, FIFO empty, state=IDLE.
- Reset asserted mid-symbol aborts immediately. After release the block starts from IDLE and no stale bits remain.
- FIFO:
  - Depth 4, circular read/write pointers plus a 3-bit count.
  - Push when ser_valid=1 at a rising edge.
  - If full and not popping that cycle, the bit is dropped and overflow<=1. overflow stays set until reset.
  - Simultaneous push and pop while full: push is accepted and count is unchanged.
  - The FSM sees a pushed bit no earlier than the next edge (registered count).
- FSM states: IDLE, RUN.
  - IDLE: mod_out=128, mod_valid=0. If FIFO non-empty: pop into cur_bit, phase<=0, sym_cnt<=0, go to RUN.
  - RUN, every edge:
    - step = cur_bit ? STEP1 : STEP0.
    - phase_n = (phase + step) mod 2^PHASE_W; phase<=phase_n.
    - mod_out<=tri(phase_n); mod_valid<=1; sym_cnt<=sym_cnt+1.
  - RUN, on the edge where sym_cnt==SAMPLES_PER_BIT-1:
    - If the FIFO is non-empty: pop the next bit into cur_bit, sym_cnt<=0, stay in RUN. There is no gap and phase is not reset (continuous phase).
    - Otherwise go to IDLE. On the following edge mod_valid<=0 and mod_out<=128.
- tri(): p = phase_n[PHASE_W-1 -: 9]. If p[8]==0, tri = p[7:0]; else tri = 255 - p[7:0].
- Latency: a bit pushed at edge k into an empty FIFO with the FSM in IDLE:
  - RUN is entered at edge k+1.
  - The first sample is registered at edge k+2.
  - Exactly SAMPLES_PER_BIT valid samples are produced per bit.
- busy is combinational: (state==RUN) | (count!=0).

Test Plan:
- Reset: hold reset=0 with toggling inputs -> mod_out=128, mod_valid=0, busy=0, overflow=0. Release with no input -> outputs unchanged for 50 cycles.
- Single 0 bit (defaults): push ser_in=0 at edge 1 -> mod_valid=1 from edge 3 for exactly 16 cycles, mod_out = 8,16,24,...,128. Then mod_valid=0, mod_out=128.
- Single 1 bit: push ser_in=1 -> 16 samples 16,32,...,240,255. mod_valid then drops.
- Back-to-back 0 then 1 (push at edges 1 and 2) -> 32 contiguous valid samples.
  - First 16: 8,...,128.
  - Next 16: phase continues from 256, giving 144,160,...,255,...,127 (peak at phase 512 → 255, falling to 255-128=127 at phase 768).
  - No gap between the two bits.
- Overflow: push 6 bits on edges 1-6 -> 5 accepted (the first is popped at edge 2), the 6th dropped, overflow=1 from edge 6. Exactly 5×16 samples follow, with bit order preserved.
- Reset mid-symbol: assert reset=0 during sample 7 of a bit with 2 bits queued -> outputs return to reset values at once. After release no samples appear until a new push.
